spi_master_xfer_engine: RTL and testbench
=========================================

# spi_master_xfer_engine

Synthesizable SPI master that originates full-duplex transfers toward the slave side of `spi_if`: it asserts chip select, generates `sclk` in all four CPOL/CPHA modes, shifts `tx_data` out on `mosi0` and captures `miso0` into `rx_data`. It is the transmitting/initiating end of the link that the slave agent monitors. It drives the HDL-top master side when a synthesizable initiator is required instead of a pure BFM.

## Interface
- `DATA_WIDTH`, 8: bits per transfer, ≥2.
- `NO_OF_SLAVES`, 1: number of chip-select lines, 1–16.
- `pclk` input 1: single system clock; every flop is on its rising edge.
- `areset` input 1: synchronous, active-high reset.
- `start` input 1: request a transfer; sampled only in IDLE.
- `cpol` input 1: clock polarity; latched at accepted start.
- `cpha` input 1: clock phase; latched at accepted start.
- `msb_first` input 1: 1 = MSB shifted first; latched.
- `clk_div` input 8: pclk cycles per sclk half-period; 0 is treated as 1; latched.
- `slave_sel` input 4: index of the cs line to assert; latched.
- `tx_data` input DATA_WIDTH: word to transmit; latched.
- `miso0` input 1: serial data from slave.
- `sclk` output 1: serial clock.
- `cs` output NO_OF_SLAVES: active-low chip selects.
- `mosi0` output 1: serial data to slave.
- `rx_data` output DATA_WIDTH: last received word, LSB-justified in arrival order per `msb_first`.
- `busy` output 1: transfer in progress.
- `done` output 1: single-cycle completion pulse.
- `err` output 1: single-cycle pulse when start is rejected for `slave_sel ≥ NO_OF_SLAVES`.

## Operation
- Reset values: `sclk`=0, `cs`=all 1, `mosi0`=0, `rx_data`=0, `busy`=0, `done`=0, `err`=0, latched cpol=0, state IDLE.
- States: IDLE → SETUP → XFER → HOLD → IDLE.
- IDLE: `sclk` = latched cpol. On `start`=1: if `slave_sel` is valid, latch all config and `tx_data` and go to SETUP; otherwise pulse `err` and stay in IDLE. Start is ignored in every other state.
- SETUP: the selected `cs` is low and `busy`=1. When cpha=0, the first data bit is already on `mosi0`. Lasts `div` cycles (`div` = max(clk_div,1)).
- XFER: 2·DATA_WIDTH sclk edges, one every `div` cycles. Edge counter runs from 0 to 2·DATA_WIDTH−1. Even edges are leading, odd edges are trailing.
  - cpha=0: sample `miso0` on leading edges; shift the next bit onto `mosi0` on trailing edges, except the last.
  - cpha=1: drive a bit on each leading edge (the first bit appears on edge 0); sample on trailing edges.
- Sampling uses the `miso0` value present in the pclk cycle in which the register toggles `sclk`.
- HOLD: `sclk` is back at idle level. `cs` stays low for `div` cycles. Then `cs` goes all-high, `busy`=0, `done`=1 and `rx_data` updates, all in the same cycle, and the state returns to IDLE.
- Minimum cs-high gap: an accepted start in the cycle after `done` is legal. `cs` is high for ≥1 cycle because SETUP begins on the next cycle.
- `areset` mid-transfer: return to reset values on the next edge. No `done`. `rx_data` is cleared.

## Timing
- Accepted start sampled at cycle 0 → `cs` low and `busy` high at cycle 1.
- sclk edge k (k = 1..2·DATA_WIDTH) at cycle 1 + k·div.
- `cs` high, `done`, `rx_data` valid at cycle 1 + (2·DATA_WIDTH+1)·div.
- Total busy cycles = (2·DATA_WIDTH+1)·div.
- `err` is asserted in cycle 1 after the rejected start.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Package `spi_master_pkg` holds:
  - `spi_state_e` (IDLE, SETUP, XFER, HOLD);
  - `spi_mode_t` struct {cpol, cpha, msb_first};
  - constants `DIV_WIDTH`=8 and `SEL_WIDTH`=4.
- Sub-module `spi_sclk_gen`: half-period counter, sclk toggle, leading/trailing edge strobes and edge counter. It takes `div`, enable and latched cpol.
- The top level holds the FSM, shift registers and cs decode.

## Test plan
- Mode 0, div=2, tx=0xA5, slave loops back `mosi0`→`miso0`, msb_first=1 → `mosi0` sequence 1,0,1,0,0,1,0,1; `rx_data`=0xA5; `done` at cycle 35.
- Modes 1/2/3 with div=1, tx=0x3C, slave returns 0xC3 → `rx_data`=0xC3; `sclk` idles at cpol; 16 edges; `done` at cycle 18.
- msb_first=0, tx=0x01, mode 0 → `mosi0`=1 only on the first bit; slave sends 0x80 LSB-first → `rx_data`=0x80.
- clk_div=0 → identical timing to clk_div=1. `slave_sel`=NO_OF_SLAVES → `err` pulse, `cs` stays all-high, `busy` stays 0.
- `start` held high across a transfer, with `tx_data` changed mid-transfer → one transfer uses the latched data. The next transfer starts the cycle after `done`, with `cs` high for exactly 1 cycle.
- `areset` asserted at edge 5 → next cycle `cs`=all 1, `sclk`=0, `busy`=0, `rx_data`=0, and no `done` pulse.

Source files
------------

// File: rtl/spi_master_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_master_pkg
// Purpose  : Shared types and constants for the SPI master transfer engine.
// Revision : 1.0 - initial release
// ============================================================================
package spi_master_pkg;

  localparam int DIV_WIDTH = 8;
  localparam int SEL_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    XFER  = 2'd2,
    HOLD  = 2'd3
  } spi_state_e;

  typedef struct packed {
    logic cpol;
    logic cpha;
    logic msb_first;
  } spi_mode_t;

endpackage
`default_nettype wire

// File: rtl/spi_sclk_gen.sv
`default_nettype none
// ============================================================================
// Module   : spi_sclk_gen
// Purpose  : Half-period divider, sclk toggle and leading/trailing strobes.
// Revision : 1.0 - initial release
// ============================================================================
module spi_sclk_gen
  import spi_master_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                 pclk,
  input  logic                 areset,
  input  logic                 en,
  input  logic                 edge_en,
  input  logic [DIV_WIDTH-1:0] div,
  input  logic                 idle_lvl,
  output logic                 sclk,
  output logic                 tick,
  output logic                 lead,
  output logic                 trail,
  output logic                 last_edge
);

  localparam int EDGES = 2 * DATA_WIDTH;
  localparam int EW    = $clog2(EDGES);
  localparam logic [EW-1:0] LAST_EDGE = EW'(EDGES - 1);

  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [EW-1:0]        edge_q, edge_d;
  logic                 sclk_q, sclk_d;
  logic                 toggle;

  assign tick      = en && (cnt_q == (div - DIV_WIDTH'(1)));
  assign toggle    = tick && edge_en;
  assign lead      = toggle && !edge_q[0];
  assign trail     = toggle && edge_q[0];
  assign last_edge = toggle && (edge_q == LAST_EDGE);
  assign sclk      = sclk_q;

  // While disabled, sclk tracks the idle level so a new cpol is visible at cs fall.
  always_comb begin
    cnt_d  = cnt_q;
    edge_d = edge_q;
    sclk_d = sclk_q;
    if (!en) begin
      cnt_d  = '0;
      edge_d = '0;
      sclk_d = idle_lvl;
    end else begin
      cnt_d = tick ? '0 : cnt_q + DIV_WIDTH'(1);
      if (toggle) begin
        edge_d = edge_q + EW'(1);
        sclk_d = !sclk_q;
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (areset) begin
      cnt_q  <= '0;
      edge_q <= '0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      edge_q <= edge_d;
      sclk_q <= sclk_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/spi_master_xfer_engine.sv
`default_nettype none
// ============================================================================
// Module   : spi_master_xfer_engine
// Purpose  : Full-duplex SPI master: FSM, shift registers and cs decode.
// Revision : 1.0 - initial release
// ============================================================================
module spi_master_xfer_engine
  import spi_master_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int NO_OF_SLAVES = 1
) (
  input  logic                    pclk,
  input  logic                    areset,
  input  logic                    start,
  input  logic                    cpol,
  input  logic                    cpha,
  input  logic                    msb_first,
  input  logic [DIV_WIDTH-1:0]    clk_div,
  input  logic [SEL_WIDTH-1:0]    slave_sel,
  input  logic [DATA_WIDTH-1:0]   tx_data,
  input  logic                    miso0,
  output logic                    sclk,
  output logic [NO_OF_SLAVES-1:0] cs,
  output logic                    mosi0,
  output logic [DATA_WIDTH-1:0]   rx_data,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  localparam int W = DATA_WIDTH;
  localparam logic [SEL_WIDTH:0]      NUM_SEL = (SEL_WIDTH + 1)'(NO_OF_SLAVES);
  localparam logic [NO_OF_SLAVES-1:0] CS_ONE  = NO_OF_SLAVES'(1);

  spi_state_e            state_q, state_d;
  spi_mode_t             mode_q, mode_d;
  logic [DIV_WIDTH-1:0]  div_q, div_d;
  logic [W-1:0]          tx_sh_q, tx_sh_d;
  logic [W-1:0]          rx_sh_q, rx_sh_d;
  logic [W-1:0]          rx_data_q, rx_data_d;
  logic [NO_OF_SLAVES-1:0] cs_q, cs_d;
  logic                  mosi_q, mosi_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic sel_ok, idle_cpol, tick, lead, trail, last_edge;
  logic first_bit, out_bit;
  logic [W-1:0] tx_rest, tx_next, rx_next;

  assign sel_ok    = {1'b0, slave_sel} < NUM_SEL;
  assign idle_cpol = (state_q == IDLE && start && sel_ok) ? cpol : mode_q.cpol;

  assign first_bit = msb_first ? tx_data[W-1] : tx_data[0];
  assign tx_rest   = msb_first ? {tx_data[W-2:0], 1'b0} : {1'b0, tx_data[W-1:1]};
  assign out_bit   = mode_q.msb_first ? tx_sh_q[W-1] : tx_sh_q[0];
  assign tx_next   = mode_q.msb_first ? {tx_sh_q[W-2:0], 1'b0} : {1'b0, tx_sh_q[W-1:1]};
  assign rx_next   = mode_q.msb_first ? {rx_sh_q[W-2:0], miso0} : {miso0, rx_sh_q[W-1:1]};

  spi_sclk_gen #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_sclk_gen (
    .pclk      (pclk),
    .areset    (areset),
    .en        (state_q != IDLE),
    .edge_en   (state_q == SETUP || state_q == XFER),
    .div       (div_q),
    .idle_lvl  (idle_cpol),
    .sclk      (sclk),
    .tick      (tick),
    .lead      (lead),
    .trail     (trail),
    .last_edge (last_edge)
  );

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    div_d     = div_q;
    tx_sh_d   = tx_sh_q;
    rx_sh_d   = rx_sh_q;
    rx_data_d = rx_data_q;
    cs_d      = cs_q;
    mosi_d    = mosi_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (sel_ok) begin
            mode_d  = '{cpol: cpol, cpha: cpha, msb_first: msb_first};
            div_d   = (clk_div == '0) ? DIV_WIDTH'(1) : clk_div;
            cs_d    = ~(CS_ONE << slave_sel);
            busy_d  = 1'b1;
            state_d = SETUP;
            // cpha=0 presents the first bit before the first sclk edge.
            if (!cpha) begin
              mosi_d  = first_bit;
              tx_sh_d = tx_rest;
            end else begin
              tx_sh_d = tx_data;
            end
          end else begin
            err_d = 1'b1;
          end
        end
      end
      SETUP: if (tick) state_d = XFER;
      XFER:  if (last_edge) state_d = HOLD;
      HOLD: begin
        if (tick) begin
          state_d   = IDLE;
          cs_d      = '1;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          rx_data_d = rx_sh_q;
        end
      end
      default: state_d = IDLE;
    endcase

    if ((lead && !mode_q.cpha) || (trail && mode_q.cpha)) begin
      rx_sh_d = rx_next;
    end
    if ((lead && mode_q.cpha) || (trail && !mode_q.cpha && !last_edge)) begin
      mosi_d  = out_bit;
      tx_sh_d = tx_next;
    end
  end

  always_ff @(posedge pclk) begin
    if (areset) begin
      state_q   <= IDLE;
      mode_q    <= '0;
      div_q     <= DIV_WIDTH'(1);
      tx_sh_q   <= '0;
      rx_sh_q   <= '0;
      rx_data_q <= '0;
      cs_q      <= '1;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      div_q     <= div_d;
      tx_sh_q   <= tx_sh_d;
      rx_sh_q   <= rx_sh_d;
      rx_data_q <= rx_data_d;
      cs_q      <= cs_d;
      mosi_q    <= mosi_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign cs      = cs_q;
  assign mosi0   = mosi_q;
  assign rx_data = rx_data_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_master_xfer_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_master_xfer_engine
// Purpose  : Self-checking bench with a behavioural SPI slave and word model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_master_xfer_engine;

  localparam int W  = 8;
  localparam int NS = 3;

  logic          pclk = 1'b0;
  logic          areset = 1'b1;
  logic          start = 1'b0;
  logic          cpol = 1'b0;
  logic          cpha = 1'b0;
  logic          msb_first = 1'b1;
  logic [7:0]    clk_div = 8'd1;
  logic [3:0]    slave_sel = 4'd0;
  logic [W-1:0]  tx_data = '0;
  logic          miso0;
  logic          sclk;
  logic [NS-1:0] cs;
  logic          mosi0;
  logic [W-1:0]  rx_data;
  logic          busy;
  logic          done;
  logic          err;

  spi_master_xfer_engine #(
    .DATA_WIDTH   (W),
    .NO_OF_SLAVES (NS)
  ) dut (
    .pclk      (pclk),
    .areset    (areset),
    .start     (start),
    .cpol      (cpol),
    .cpha      (cpha),
    .msb_first (msb_first),
    .clk_div   (clk_div),
    .slave_sel (slave_sel),
    .tx_data   (tx_data),
    .miso0     (miso0),
    .sclk      (sclk),
    .cs        (cs),
    .mosi0     (mosi0),
    .rx_data   (rx_data),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 pclk = ~pclk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Behavioural slave: shifts sl_word out and assembles the received word.
  logic         sl_cpol = 1'b0, sl_cpha = 1'b0, sl_msb = 1'b1;
  int           sl_sel = 0;
  logic [W-1:0] sl_word = '0, sl_got = '0;
  logic         sl_miso = 1'b0, sl_prev = 1'b0;
  bit           sl_act = 1'b0, loopback = 1'b0;
  int           sl_drv = 0, sl_smp = 0, sl_edges = 0;

  assign miso0 = loopback ? mosi0 : sl_miso;

  always @(negedge pclk) begin
    if (cs[sl_sel] !== 1'b0) begin
      sl_act = 1'b0;
    end else begin
      if (!sl_act) begin
        sl_act = 1'b1; sl_prev = sclk; sl_drv = 0; sl_smp = 0; sl_edges = 0; sl_got = '0;
        if (!sl_cpha) begin
          sl_miso = sl_word[sl_msb ? W-1 : 0];
          sl_drv  = 1;
        end
      end
      if (sclk !== sl_prev) begin
        sl_edges++;
        if ((sl_prev === sl_cpol) ^ sl_cpha) begin
          if (sl_smp < W) sl_got[sl_msb ? W-1-sl_smp : sl_smp] = mosi0;
          sl_smp++;
        end else if (sl_drv < W) begin
          sl_miso = sl_word[sl_msb ? W-1-sl_drv : sl_drv];
          sl_drv++;
        end
        sl_prev = sclk;
      end
    end
  end

  // Follows one transfer from the cycle after its accepting edge through done.
  task automatic xfer(input logic [W-1:0] exp_tx, input logic [W-1:0] exp_rx,
                      input int div_eff, input int sel, input logic pol, input bit hold,
                      input int chg_cyc, input logic [W-1:0] chg_tx, input string tag);
    int cyc, busy_n, done_cyc;
    logic [NS-1:0] exp_cs;
    exp_cs = '1;
    exp_cs[sel] = 1'b0;
    @(posedge pclk); #1;
    cyc = 1;
    if (!hold) start = 1'b0;
    chk({tag, ".cs_sel"}, 32'(cs), 32'(exp_cs));
    chk({tag, ".busy"}, 32'(busy), 32'd1);
    chk({tag, ".sclk_start"}, 32'(sclk), 32'(pol));
    busy_n = 1;
    done_cyc = 0;
    while (done_cyc == 0 && cyc < 2000) begin
      @(posedge pclk); #1;
      cyc++;
      if (cyc == chg_cyc) tx_data = chg_tx;
      if (busy) busy_n++;
      if (done) done_cyc = cyc;
    end
    chk({tag, ".done_cyc"}, 32'(done_cyc), 32'(1 + (2*W+1)*div_eff));
    chk({tag, ".busy_cyc"}, 32'(busy_n), 32'((2*W+1)*div_eff));
    chk({tag, ".cs_idle"}, 32'(cs), 32'((1 << NS) - 1));
    chk({tag, ".sclk_end"}, 32'(sclk), 32'(pol));
    chk({tag, ".rx"}, 32'(rx_data), 32'(exp_rx));
    chk({tag, ".mosi_word"}, 32'(sl_got), 32'(exp_tx));
    chk({tag, ".edges"}, 32'(sl_edges), 32'(2*W));
  endtask

  task automatic go(input logic p, input logic ph, input logic m, input int div, input int sel,
                    input logic [W-1:0] tx, input logic [W-1:0] sw, input bit lb, input string tag);
    @(negedge pclk);
    cpol = p; cpha = ph; msb_first = m; clk_div = 8'(div); slave_sel = 4'(sel); tx_data = tx;
    sl_cpol = p; sl_cpha = ph; sl_msb = m; sl_sel = sel; sl_word = sw; loopback = lb;
    start = 1'b1;
    xfer(tx, lb ? tx : sw, (div == 0) ? 1 : div, sel, p, 1'b0, 0, '0, tag);
    @(posedge pclk); #1;
    chk({tag, ".done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int done_seen;
    repeat (3) @(posedge pclk);
    #1;
    chk("rst.sclk", 32'(sclk), 32'd0);
    chk("rst.cs", 32'(cs), 32'((1 << NS) - 1));
    chk("rst.mosi", 32'(mosi0), 32'd0);
    chk("rst.rx", 32'(rx_data), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.err", 32'(err), 32'd0);
    @(negedge pclk);
    areset = 1'b0;

    go(1'b0, 1'b0, 1'b1, 2, 0, 8'hA5, 8'h00, 1'b1, "mode0_loop");
    go(1'b0, 1'b1, 1'b1, 1, 1, 8'h3C, 8'hC3, 1'b0, "mode1");
    go(1'b1, 1'b0, 1'b1, 1, 2, 8'h3C, 8'hC3, 1'b0, "mode2");
    go(1'b1, 1'b1, 1'b1, 1, 0, 8'h3C, 8'hC3, 1'b0, "mode3");
    go(1'b0, 1'b0, 1'b0, 1, 0, 8'h01, 8'h80, 1'b0, "lsb_first");
    go(1'b0, 1'b1, 1'b0, 0, 1, 8'h96, 8'h4B, 1'b0, "div0");

    // Out-of-range select is rejected with a one-cycle err pulse.
    @(negedge pclk);
    slave_sel = 4'(NS);
    start = 1'b1;
    @(posedge pclk); #1;
    start = 1'b0;
    chk("bad_sel.err", 32'(err), 32'd1);
    chk("bad_sel.busy", 32'(busy), 32'd0);
    chk("bad_sel.cs", 32'(cs), 32'((1 << NS) - 1));
    @(posedge pclk); #1;
    chk("bad_sel.err_pulse", 32'(err), 32'd0);
    chk("bad_sel.busy2", 32'(busy), 32'd0);

    for (int i = 0; i < 12; i++) begin
      go(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
         $urandom_range(0, 3), $urandom_range(0, NS-1), W'($urandom), W'($urandom),
         1'b0, $sformatf("rnd%0d", i));
    end

    // start held high: latched data used, second transfer follows done directly.
    @(negedge pclk);
    cpol = 1'b0; cpha = 1'b0; msb_first = 1'b1; clk_div = 8'd1; slave_sel = 4'd0;
    tx_data = 8'h5A;
    sl_cpol = 1'b0; sl_cpha = 1'b0; sl_msb = 1'b1; sl_sel = 0; sl_word = 8'h69;
    loopback = 1'b0;
    start = 1'b1;
    xfer(8'h5A, 8'h69, 1, 0, 1'b0, 1'b1, 5, 8'h96, "b2b_first");
    xfer(8'h96, 8'h69, 1, 0, 1'b0, 1'b0, 0, '0, "b2b_second");
    @(posedge pclk); #1;
    chk("b2b.no_third", 32'(busy), 32'd0);

    // Reset mid-transfer after the fifth sclk edge.
    @(negedge pclk);
    cpol = 1'b1; cpha = 1'b0; clk_div = 8'd2; slave_sel = 4'd1; tx_data = 8'hC7;
    sl_cpol = 1'b1; sl_cpha = 1'b0; sl_sel = 1; sl_word = 8'h12;
    start = 1'b1;
    @(posedge pclk); #1;
    start = 1'b0;
    repeat (10) @(posedge pclk);
    #1;
    chk("arst.busy_before", 32'(busy), 32'd1);
    areset = 1'b1;
    @(posedge pclk); #1;
    areset = 1'b0;
    chk("arst.cs", 32'(cs), 32'((1 << NS) - 1));
    chk("arst.sclk", 32'(sclk), 32'd0);
    chk("arst.busy", 32'(busy), 32'd0);
    chk("arst.rx", 32'(rx_data), 32'd0);
    chk("arst.mosi", 32'(mosi0), 32'd0);
    done_seen = 0;
    repeat (60) begin
      @(posedge pclk); #1;
      if (done) done_seen++;
    end
    chk("arst.no_done", 32'(done_seen), 32'd0);
    chk("arst.idle_sclk", 32'(sclk), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
